fp_add_arbiter: RTL and testbench

- Shares one 32-bit floating-point adder wrapper among NUM_REQ independent requesters.
- The adder wrapper has user-side ports a/b/ready_in/out/ready_out.
- Arbitration is round-robin. The block holds one operation in flight, captures the sum, and returns it to the owning requester.
- A watchdog returns an error response if the adder never completes.

---
 rtl/fp_add_arb_pkg.sv | 40 ++++
 rtl/fp_add_arbiter_rr.sv | 25 ++
 rtl/fp_add_arbiter.sv | 130 +++++++++++++
 tb/tb_fp_add_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_arb_pkg.sv
// rtl/fp_add_arb_pkg.sv - shared types, constants and round-robin pick helper
package fp_add_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [31:0] FP_QNAN  = 32'h7FC00000;
  localparam int          MAX_REQ  = 8;
  localparam int          IDX_W    = 3;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Lowest offset from ptr wins, so iterate from the far end and let later hits overwrite.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [IDX_W-1:0]   ptr,
                                       input int                 n);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (req[j]) begin
          r.found = 1'b1;
          r.idx   = IDX_W'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_add_arbiter_rr.sv
// rtl/fp_add_arbiter_rr.sv - combinational round-robin pick among NUM_REQ requesters
module rr_arbiter
  import fp_add_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  rr_pick_t           pick;
  logic [MAX_REQ-1:0] req_ext;

  always_comb begin
    req_ext = MAX_REQ'(req);
    pick    = rr_pick(req_ext, ptr, NUM_REQ);
    any     = pick.found;
    idx     = pick.idx;
    grant   = pick.found ? (NUM_REQ'(1) << pick.idx) : '0;
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - shares one FP adder among NUM_REQ requesters, one op in flight
module fp_add_arbiter
  import fp_add_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_data,
  output logic                   rsp_err,
  output logic [31:0]            a,
  output logic [31:0]            b,
  output logic                   ready_in,
  input  logic [31:0]            out,
  input  logic                   ready_out,
  output logic                   busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               ready_out_q, ready_out_d;
  logic [TW-1:0]      timer_q, timer_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               done_edge;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // A level already high on WAIT entry has ready_out_q set, so it never looks like an edge.
  assign done_edge = ready_out && !ready_out_q;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    timer_d     = timer_q;
    ready_out_d = ready_out;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          gnt_d   = arb_idx;
          a_d     = req_a[32*arb_idx +: 32];
          b_d     = req_b[32*arb_idx +: 32];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (done_edge) begin
          rsp_data_d = out;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rsp_data_d = FP_QNAN;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RESP: begin
        rr_ptr_d = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      ready_out_q <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      ready_out_q <= ready_out_d;
      timer_q     <= timer_d;
    end
  end

  // The accept pulse is combinational with the grant, so keep it quiet while reset is held.
  assign req_ready = (state_q == IDLE && reset_n) ? arb_grant : '0;
  assign rsp_valid = (state_q == RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign a         = a_q;
  assign b         = b_q;
  assign ready_in  = (state_q == ISSUE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb/tb_fp_add_arbiter.sv - directed self-checking bench for fp_add_arbiter
module tb_fp_add_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N*32-1:0] req_a, req_b;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [31:0]    rsp_data, a, b;
  logic           rsp_err, ready_in, busy;
  logic [31:0]    out;
  logic           ready_out;

  logic           model_en;
  int             model_delay;
  logic           model_ro;
  logic [31:0]    model_out;
  logic           man_ro;
  logic [31:0]    man_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  assign ready_out = model_ro | man_ro;
  assign out       = model_ro ? model_out : man_out;

  fp_add_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .a         (a),
    .b         (b),
    .ready_in  (ready_in),
    .out       (out),
    .ready_out (ready_out),
    .busy      (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] fp_lut(input logic [31:0] x, input logic [31:0] y);
    case ({x, y})
      {32'h3F9D70A4, 32'h4091EB85}: return 32'h40B947AE;
      {32'h473FF936, 32'hC6DDE29C}: return 32'h46A20FD0;
      {32'h44F6AF68, 32'h4610099B}: return 32'h462EDF88;
      {32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {32'h40000000, 32'h40400000}: return 32'h40A00000;
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  // Adder model: result pulse model_delay negedges after the start pulse is seen.
  initial begin
    model_ro  = 1'b0;
    model_out = '0;
    forever begin
      @(negedge clock);
      if (model_en && ready_in) begin
        repeat (model_delay) @(negedge clock);
        model_out = fp_lut(a, b);
        model_ro  = 1'b1;
        @(negedge clock);
        model_ro  = 1'b0;
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y);
    req_a[32*i +: 32] = x;
    req_b[32*i +: 32] = y;
    req_valid[i]      = 1'b1;
  endtask

  task automatic wait_grant(output bit ok, output int t);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (|req_ready) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic wait_rsp(output bit ok, output int t);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (|rsp_valid) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    man_ro    = 1'b0;
    man_out   = '0;
    model_en  = 1'b0;
    model_delay = 1;
    repeat (3) @(negedge clock);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, ready_in, busy} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0", {req_ready, rsp_valid, rsp_err, ready_in, busy});
    end
    checks++;
    if ({rsp_data, a, b} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {rsp_data, a, b});
    end
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_single;
    bit ok;
    int tg, ti, tr;
    model_en    = 1'b1;
    model_delay = 5;
    set_req(0, 32'h3F9D70A4, 32'h4091EB85);
    wait_grant(ok, tg);
    checks++;
    if (!ok || req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant: got %b expected 0001", req_ready);
    end
    @(posedge clock);
    #1 req_valid[0] = 1'b0;
    @(negedge clock);
    ti = cyc;
    checks++;
    if (ready_in !== 1'b1 || ti != tg + 1) begin
      errors++;
      $display("FAIL single_issue: ready_in %b at +%0d expected 1 at +1", ready_in, ti - tg);
    end
    checks++;
    if (a !== 32'h3F9D70A4 || b !== 32'h4091EB85) begin
      errors++;
      $display("FAIL single_operands: got %h %h expected 3f9d70a4 4091eb85", a, b);
    end
    wait_rsp(ok, tr);
    checks++;
    if (!ok || rsp_valid !== 4'b0001 || tr != ti + 6) begin
      errors++;
      $display("FAIL single_rsp_timing: rsp_valid %b at +%0d expected 0001 at +6", rsp_valid, tr - ti);
    end
    checks++;
    if (rsp_data !== 32'h40B947AE || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp_data: got %h err %b expected 40b947ae err 0", rsp_data, rsp_err);
    end
  endtask

  task automatic test_round_robin;
    bit ok;
    int tg, tr, g;
    logic [31:0] exp_sum [N];
    exp_sum[0] = 32'h40000000;
    exp_sum[1] = 32'h40A00000;
    exp_sum[2] = 32'h46A20FD0;
    exp_sum[3] = 32'h40400000;
    reset_n = 1'b0;
    model_en    = 1'b1;
    model_delay = 2;
    set_req(0, 32'h3F800000, 32'h3F800000);
    set_req(1, 32'h40000000, 32'h40400000);
    set_req(2, 32'h473FF936, 32'hC6DDE29C);
    set_req(3, 32'h3F800000, 32'h40000000);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      g = k % N;
      wait_grant(ok, tg);
      checks++;
      if (!ok || req_ready !== (4'b0001 << g)) begin
        errors++;
        $display("FAIL rr_grant_%0d: got %b expected %b", k, req_ready, 4'b0001 << g);
      end
      @(posedge clock);
      #1;
      if (k == 4) req_valid = '0;
      wait_rsp(ok, tr);
      checks++;
      if (!ok || rsp_valid !== (4'b0001 << g) || rsp_data !== exp_sum[g] || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL rr_rsp_%0d: valid %b data %h err %b expected %b %h 0",
                 k, rsp_valid, rsp_data, rsp_err, 4'b0001 << g, exp_sum[g]);
      end
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int tg, ti, tr;
    model_en = 1'b0;
    @(negedge clock);
    set_req(1, 32'h40000000, 32'h40400000);
    wait_grant(ok, tg);
    @(posedge clock);
    #1 req_valid[1] = 1'b0;
    @(negedge clock);
    ti = cyc;
    wait_rsp(ok, tr);
    checks++;
    if (!ok || rsp_valid !== 4'b0010 || tr != ti + 9) begin
      errors++;
      $display("FAIL timeout_timing: rsp_valid %b at +%0d expected 0010 at +9", rsp_valid, tr - ti);
    end
    checks++;
    if (rsp_data !== 32'h7FC00000 || rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_data: got %h err %b expected 7fc00000 err 1", rsp_data, rsp_err);
    end
    model_en    = 1'b1;
    model_delay = 3;
    @(negedge clock);
    set_req(2, 32'h3F800000, 32'h3F800000);
    wait_grant(ok, tg);
    @(posedge clock);
    #1 req_valid[2] = 1'b0;
    wait_rsp(ok, tr);
    checks++;
    if (!ok || rsp_valid !== 4'b0100 || rsp_data !== 32'h40000000 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL after_timeout: valid %b data %h err %b expected 0100 40000000 0", rsp_valid, rsp_data, rsp_err);
    end
  endtask

  task automatic test_ready_held_high;
    bit ok;
    bit early;
    int tg;
    model_en = 1'b0;
    @(negedge clock);
    man_ro  = 1'b1;
    man_out = 32'h00000000;
    set_req(0, 32'h44F6AF68, 32'h4610099B);
    wait_grant(ok, tg);
    @(posedge clock);
    #1 req_valid[0] = 1'b0;
    @(negedge clock);
    early = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      if (|rsp_valid) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL held_high_no_complete: got early response expected none");
    end
    man_ro = 1'b0;
    @(negedge clock);
    man_out = 32'h462EDF88;
    man_ro  = 1'b1;
    @(negedge clock);
    man_ro  = 1'b0;
    man_out = 32'h00000000;
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 32'h462EDF88 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL held_high_rsp: valid %b data %h err %b expected 0001 462edf88 0", rsp_valid, rsp_data, rsp_err);
    end
  endtask

  task automatic test_same_cycle;
    bit ok;
    int tg, ti, tr;
    model_en    = 1'b1;
    model_delay = 8;
    @(negedge clock);
    set_req(1, 32'h3F800000, 32'h40000000);
    wait_grant(ok, tg);
    @(posedge clock);
    #1 req_valid[1] = 1'b0;
    @(negedge clock);
    ti = cyc;
    wait_rsp(ok, tr);
    checks++;
    if (!ok || tr != ti + 9 || rsp_err !== 1'b0 || rsp_data !== 32'h40400000) begin
      errors++;
      $display("FAIL same_cycle: at +%0d data %h err %b expected +9 40400000 0", tr - ti, rsp_data, rsp_err);
    end
  endtask

  task automatic test_reset_in_wait;
    bit ok;
    bit stray;
    int tg, tr;
    model_en = 1'b0;
    @(negedge clock);
    set_req(1, 32'h3F800000, 32'h40000000);
    wait_grant(ok, tg);
    @(posedge clock);
    #1 req_valid[1] = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, ready_in, busy} !== '0 || {rsp_data, a, b} !== '0) begin
      errors++;
      $display("FAIL reset_in_wait: ctrl %b data %h expected all 0",
               {req_ready, rsp_valid, rsp_err, ready_in, busy}, {rsp_data, a, b});
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    stray = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clock);
      if (|rsp_valid) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL reset_no_rsp: got response after reset expected none");
    end
    model_en    = 1'b1;
    model_delay = 2;
    set_req(3, 32'h40000000, 32'h40400000);
    wait_grant(ok, tg);
    checks++;
    if (!ok || req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL post_reset_grant: got %b expected 1000", req_ready);
    end
    @(posedge clock);
    #1 req_valid[3] = 1'b0;
    wait_rsp(ok, tr);
    checks++;
    if (!ok || rsp_valid !== 4'b1000 || rsp_data !== 32'h40A00000 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_rsp: valid %b data %h err %b expected 1000 40a00000 0", rsp_valid, rsp_data, rsp_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_ready_held_high();
    test_same_cycle();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
